// File: rtl/unsigned_div_seq.sv
// Sequential restoring divider: one quotient bit per clock, start/busy/done handshake.
// Divide-by-zero short-circuits to DONE with quot all ones and rem equal to the dividend.
module unsigned_div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] dividend_work;
    logic [WIDTH-1:0] divisor_work;
    logic [WIDTH-1:0] part_rem;
    logic             accept;
    logic             accept_zero;
    logic             last_step;
    logic [WIDTH:0]   step_res;
    logic             step_bit;
    logic [WIDTH-1:0] step_rem;

    // One restoring iteration: returns {quotient bit, new partial remainder}.
    // The shifted remainder is WIDTH+1 bits; when it is >= divisor the
    // difference is below 2^WIDTH, so its low WIDTH bits are exact.
    function automatic logic [WIDTH:0] restore_step(
        input logic [WIDTH-1:0] r,
        input logic             b,
        input logic [WIDTH-1:0] d
    );
        logic [WIDTH:0]   shifted;
        logic [WIDTH-1:0] diff;
        shifted = {r, b};
        diff    = shifted[WIDTH-1:0] - d;
        if (shifted >= {1'b0, d})
            return {1'b1, diff};
        else
            return {1'b0, shifted[WIDTH-1:0]};
    endfunction

    assign step_res  = restore_step(part_rem, dividend_work[WIDTH-1], divisor_work);
    assign step_bit  = step_res[WIDTH];
    assign step_rem  = step_res[WIDTH-1:0];
    assign last_step = (count == CNT_W'(WIDTH - 1));

    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        accept_zero = 1'b0;
        case (state)
            IDLE, DONE: begin
                state_next = IDLE;
                if (start) begin
                    if (in2 == '0) begin
                        accept_zero = 1'b1;
                        state_next  = DONE;
                    end else begin
                        accept     = 1'b1;
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                if (last_step)
                    state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Control and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            count       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quot        <= '0;
            rem         <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next == RUN);
            done  <= (state_next == DONE);
            if (accept)
                count <= '0;
            else if (state == RUN)
                count <= count + 1'b1;
            if (accept_zero) begin
                quot        <= '1;
                rem         <= in1;
                div_by_zero <= 1'b1;
            end else if (state == RUN && last_step) begin
                quot        <= {dividend_work[WIDTH-2:0], step_bit};
                rem         <= step_rem;
                div_by_zero <= 1'b0;
            end
        end
    end

    // Working datapath: the dividend register shifts out dividend bits MSB
    // first while quotient bits shift in at the bottom.
    always_ff @(posedge clk) begin
        if (accept) begin
            dividend_work <= in1;
            divisor_work  <= in2;
            part_rem      <= '0;
        end else if (state == RUN) begin
            dividend_work <= {dividend_work[WIDTH-2:0], step_bit};
            part_rem      <= step_rem;
        end
    end

endmodule

// File: tb/tb_unsigned_div_seq.sv
// Directed and random bench for unsigned_div_seq (WIDTH=32): handshake timing,
// back-to-back, divide-by-zero, ignored start, mid-run reset and quotient/remainder identity.
module tb_unsigned_div_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] in1 = '0;
    logic [W-1:0] in2 = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quot;
    logic [W-1:0] rem;
    logic         div_by_zero;

    int total = 0;
    int bad = 0;

    unsigned_div_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in1(in1), .in2(in2),
        .busy(busy), .done(done), .quot(quot), .rem(rem), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // Waits for done, sampling on falling edges; start is dropped after the first edge.
    task automatic wait_done(input int limit, output int cyc, output int busy_cnt,
                             output bit overlap, output bit timeout);
        cyc = 0; busy_cnt = 0; overlap = 1'b0;
        do begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (busy) busy_cnt++;
            if (busy && done) overlap = 1'b1;
        end while (!done && cyc < limit);
        timeout = !done;
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1; in1 = a; in2 = b;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, done, div_by_zero} !== 3'b000) begin
            bad++; $display("FAIL reset_ctrl got=%b want=000", {busy, done, div_by_zero});
        end
        total++;
        if (quot !== '0 || rem !== '0) begin
            bad++; $display("FAIL reset_data got quot=%0h rem=%0h want 0/0", quot, rem);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int cyc, bc; bit ov, to;
        @(negedge clk);
        issue(32'd100, 32'd7);
        wait_done(40, cyc, bc, ov, to);
        total++;
        if (to || cyc !== 33) begin
            bad++; $display("FAIL basic_latency got=%0d timeout=%0d want=33", cyc, to);
        end
        total++;
        if (bc !== 32) begin bad++; $display("FAIL basic_busy_cycles got=%0d want=32", bc); end
        total++;
        if (ov !== 1'b0) begin bad++; $display("FAIL basic_busy_done_overlap got=1 want=0"); end
        total++;
        if (quot !== 32'd14 || rem !== 32'd2 || div_by_zero !== 1'b0) begin
            bad++; $display("FAIL basic_result got q=%0d r=%0d z=%0d want 14/2/0", quot, rem, div_by_zero);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || quot !== 32'd14 || rem !== 32'd2) begin
            bad++; $display("FAIL basic_hold got done=%0d q=%0d r=%0d want 0/14/2", done, quot, rem);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, bc; bit ov, to;
        @(negedge clk);
        issue(32'hFFFF_FFFF, 32'd1);
        wait_done(40, cyc, bc, ov, to);
        total++;
        if (to || quot !== 32'hFFFF_FFFF || rem !== 32'd0) begin
            bad++; $display("FAIL b2b_first got q=%0h r=%0h timeout=%0d want ffffffff/0", quot, rem, to);
        end
        issue(32'd3, 32'd10);
        wait_done(40, cyc, bc, ov, to);
        total++;
        if (to || cyc !== 33) begin
            bad++; $display("FAIL b2b_latency got=%0d timeout=%0d want=33", cyc, to);
        end
        total++;
        if (quot !== 32'd0 || rem !== 32'd3) begin
            bad++; $display("FAIL b2b_second got q=%0d r=%0d want 0/3", quot, rem);
        end
    endtask

    task automatic test_div_zero();
        int cyc, bc; bit ov, to;
        @(negedge clk);
        issue(32'd5, 32'd0);
        wait_done(5, cyc, bc, ov, to);
        total++;
        if (to || cyc !== 1 || bc !== 0) begin
            bad++; $display("FAIL dz_timing got cyc=%0d busy=%0d timeout=%0d want 1/0", cyc, bc, to);
        end
        total++;
        if (quot !== 32'hFFFF_FFFF || rem !== 32'd5 || div_by_zero !== 1'b1) begin
            bad++; $display("FAIL dz_result got q=%0h r=%0d z=%0d want ffffffff/5/1", quot, rem, div_by_zero);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || div_by_zero !== 1'b1) begin
            bad++; $display("FAIL dz_after got done=%0d busy=%0d z=%0d want 0/0/1", done, busy, div_by_zero);
        end
        issue(32'd20, 32'd6);
        wait_done(40, cyc, bc, ov, to);
        total++;
        if (to || quot !== 32'd3 || rem !== 32'd2 || div_by_zero !== 1'b0) begin
            bad++; $display("FAIL dz_clear got q=%0d r=%0d z=%0d want 3/2/0", quot, rem, div_by_zero);
        end
    endtask

    task automatic test_start_ignored();
        int pulses = 0;
        int done_cyc = 0;
        logic [W-1:0] q_cap = '0;
        logic [W-1:0] r_cap = '0;
        @(negedge clk);
        issue(32'd100, 32'd7);
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (done) begin pulses++; done_cyc = c; q_cap = quot; r_cap = rem; end
            if (c == 10) issue(32'd9, 32'd3);
            if (c == 11) start = 1'b0;
        end
        total++;
        if (pulses !== 1 || done_cyc !== 33) begin
            bad++; $display("FAIL ign_pulses got pulses=%0d at=%0d want 1 at 33", pulses, done_cyc);
        end
        total++;
        if (q_cap !== 32'd14 || r_cap !== 32'd2) begin
            bad++; $display("FAIL ign_result got q=%0d r=%0d want 14/2", q_cap, r_cap);
        end
    endtask

    task automatic test_reset_mid_run();
        int cyc, bc; bit ov, to;
        int stray = 0;
        @(negedge clk);
        issue(32'd100, 32'd7);
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) stray++;
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, div_by_zero} !== 3'b000 || quot !== '0 || rem !== '0) begin
            bad++; $display("FAIL midrst_clear got b=%0d d=%0d z=%0d q=%0d r=%0d want all 0",
                            busy, done, div_by_zero, quot, rem);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (done || busy) stray++;
        end
        total++;
        if (stray !== 0) begin bad++; $display("FAIL midrst_no_done got=%0d want=0", stray); end
        issue(32'd50, 32'd50);
        wait_done(40, cyc, bc, ov, to);
        total++;
        if (to || cyc !== 33 || quot !== 32'd1 || rem !== 32'd0) begin
            bad++; $display("FAIL midrst_after got cyc=%0d q=%0d r=%0d want 33/1/0", cyc, quot, rem);
        end
    endtask

    task automatic test_vectors();
        logic [W-1:0] va [8] = '{32'd0, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFE,
                                 32'd1000, 32'h8000_0000, 32'd100, 32'd1};
        logic [W-1:0] vb [8] = '{32'd5, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                 32'd10, 32'd2, 32'd3, 32'h8000_0000};
        logic [W-1:0] vq [8] = '{32'd0, 32'd1, 32'd1, 32'd0,
                                 32'd100, 32'h4000_0000, 32'd33, 32'd0};
        logic [W-1:0] vr [8] = '{32'd0, 32'd0, 32'd0, 32'hFFFF_FFFE,
                                 32'd0, 32'd0, 32'd1, 32'd1};
        int cyc, bc; bit ov, to;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            issue(va[i], vb[i]);
            wait_done(40, cyc, bc, ov, to);
            total++;
            if (to || quot !== vq[i] || rem !== vr[i]) begin
                bad++; $display("FAIL vec%0d got q=%0h r=%0h want q=%0h r=%0h", i, quot, rem, vq[i], vr[i]);
            end
        end
    endtask

    task automatic test_random();
        int cyc, bc; bit ov, to;
        logic [W-1:0] a, b;
        logic [2*W-1:0] recon;
        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            b = (i % 3 == 0) ? W'($urandom_range(1, 1000)) : W'($urandom);
            if (b == '0) b = 32'd1;
            @(negedge clk);
            issue(a, b);
            wait_done(40, cyc, bc, ov, to);
            recon = {{W{1'b0}}, quot} * {{W{1'b0}}, b} + {{W{1'b0}}, rem};
            total++;
            if (to || recon !== {{W{1'b0}}, a} || rem >= b || ov) begin
                bad++; $display("FAIL rand%0d a=%0h b=%0h got q=%0h r=%0h timeout=%0d", i, a, b, quot, rem, to);
            end
            total++;
            if (quot !== a / b || rem !== a % b) begin
                bad++; $display("FAIL rand_ref%0d got q=%0h r=%0h want q=%0h r=%0h", i, quot, rem, a / b, a % b);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_div_zero();
        test_start_ignored();
        test_reset_mid_run();
        test_vectors();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
